// File: rtl/vend_pkg.sv
// vend_pkg: money width, coin values and dispenser state encoding shared by the change path.
package vend_pkg;
   localparam int MONEY_W      = 11;
   localparam int COIN_DOLLAR  = 100;
   localparam int COIN_QUARTER = 25;
   localparam int COIN_DIME    = 10;
   localparam int COIN_NICKEL  = 5;
   typedef enum logic [1:0] {IDLE, LOAD, DISPENSE, DONE} state_t;
endpackage

// File: rtl/coin_select.sv
// coin_select: greedy picker, largest coin not exceeding remaining; sel is {dollar,quarter,dime,nickel}.
// CHANGE_DOLLAR_EN enables the dollar coin; otherwise the quarter is the largest coin.
module coin_select
   import vend_pkg::*;
#(
   parameter int W = MONEY_W
) (
   input  logic [W-1:0] remaining,
   output logic [3:0]   sel,
   output logic [W-1:0] value
);
   logic dollar_ok;
`ifdef CHANGE_DOLLAR_EN
   assign dollar_ok = remaining >= W'(COIN_DOLLAR);
`else
   assign dollar_ok = 1'b0;
`endif
   always_comb begin
      sel   = dollar_ok                       ? 4'b1000 :
              remaining >= W'(COIN_QUARTER)   ? 4'b0100 :
              remaining >= W'(COIN_DIME)      ? 4'b0010 :
              remaining >= W'(COIN_NICKEL)    ? 4'b0001 : 4'b0000;
      value = sel[3] ? W'(COIN_DOLLAR)  :
              sel[2] ? W'(COIN_QUARTER) :
              sel[1] ? W'(COIN_DIME)    :
              sel[0] ? W'(COIN_NICKEL)  : '0;
   end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: computes change on a vend and ejects it one coin per GAP-cycle slot, largest first.
// The dollar coin is only used when CHANGE_DOLLAR_EN is defined (handled inside coin_select).
module change_dispenser
   import vend_pkg::*;
#(
   parameter int W   = MONEY_W,
   parameter int GAP = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         vend_req,
   input  logic [W-1:0] paid,
   input  logic [W-1:0] price,
   input  logic         credit,
   output logic         ej_dollar,
   output logic         ej_quarter,
   output logic         ej_dime,
   output logic         ej_nickel,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] remaining
);
   localparam logic [3:0]   LAST = 4'(GAP - 1);
   localparam logic [W-1:0] MIN  = W'(COIN_NICKEL);
   state_t       state;
   logic [W-1:0] paid_q, price_q, change, pick_in, pick_val;
   logic         credit_q;
   logic [3:0]   cnt, pick, ej;
   assign change  = (credit_q || paid_q <= price_q) ? '0 : paid_q - price_q;
   // LOAD picks from the fresh change so the first pulse lands right after LOAD
   assign pick_in = state == LOAD ? change : remaining;
   assign {ej_dollar, ej_quarter, ej_dime, ej_nickel} = ej;
   coin_select #(.W(W)) u_sel (
      .remaining(pick_in),
      .sel      (pick),
      .value    (pick_val)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         paid_q    <= '0;
         price_q   <= '0;
         credit_q  <= 1'b0;
         cnt       <= '0;
         ej        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (vend_req) begin
                  paid_q   <= paid;
                  price_q  <= price;
                  credit_q <= credit;
                  busy     <= 1'b1;
                  state    <= LOAD;
               end
            end
            LOAD: begin
               remaining <= change;
               cnt       <= '0;
               ej        <= change >= MIN ? pick : '0;
               state     <= change >= MIN ? DISPENSE : DONE;
               done      <= change < MIN;
            end
            DISPENSE: begin
               cnt <= cnt + 4'd1;
               ej  <= '0;
               if (cnt == '0) remaining <= remaining - pick_val;
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (remaining < MIN) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     ej <= pick;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: random and directed vends checked cycle by cycle against a greedy coin-list model.
module tb_change_dispenser;
   localparam int W   = 11;
   localparam int GAP = 4;
   logic         clk = 1'b0, rst_n = 1'b0, vend_req = 1'b0, credit = 1'b0;
   logic [W-1:0] paid = '0, price = '0;
   logic         ej_dollar, ej_quarter, ej_dime, ej_nickel, busy, done;
   logic [W-1:0] remaining;
   int vectors = 0, errors = 0;

   change_dispenser #(.W(W), .GAP(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .vend_req(vend_req), .paid(paid), .price(price), .credit(credit),
      .ej_dollar(ej_dollar), .ej_quarter(ej_quarter), .ej_dime(ej_dime), .ej_nickel(ej_nickel),
      .busy(busy), .done(done), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   function automatic logic [3:0] coin_mask(input int v);
      return v == 100 ? 4'b1000 : v == 25 ? 4'b0100 : v == 10 ? 4'b0010 : v == 5 ? 4'b0001 : 4'b0000;
   endfunction

   function automatic logic [3:0] ej_now();
      return {ej_dollar, ej_quarter, ej_dime, ej_nickel};
   endfunction

   // Caller is at a negedge with the DUT idle; that cycle is cycle 0 of the vend.
   task automatic vend(input int p, input int pr, input int c, input int xreq, input int abort);
      int denoms[4] = '{100, 25, 10, 5};
      int coins[$];
      int ch, rem, n, done_t, r;
      logic [3:0] exp_ej;
`ifdef CHANGE_DOLLAR_EN
      int first = 0;
`else
      int first = 1;
`endif
      ch  = (c != 0 || p <= pr) ? 0 : p - pr;
      rem = ch;
      while (rem >= 5) begin
         for (int i = first; i < 4; i++)
            if (denoms[i] <= rem) begin
               coins.push_back(denoms[i]);
               rem -= denoms[i];
               break;
            end
      end
      n      = coins.size();
      done_t = 2 + n * GAP;
      paid = W'(p); price = W'(pr); credit = c[0]; vend_req = 1'b1;
      check("idle_busy", busy, 0);
      for (int t = 1; t <= done_t; t++) begin
         @(posedge clk); @(negedge clk);
         vend_req = (t == xreq);
         paid     = W'($urandom_range(0, 2047));
         price    = W'($urandom_range(0, 2047));
         credit   = 1'($urandom_range(0, 1));
         if (t == abort) begin
            rst_n = 1'b0;
            #1;
            check("abort_ej", ej_now(), 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_remaining", remaining, 0);
            vend_req = 1'b0;
            repeat (2) begin
               @(posedge clk); @(negedge clk);
               check("abort_quiet", {ej_now(), busy, done}, 0);
            end
            rst_n = 1'b1;
            return;
         end
         exp_ej = '0;
         if (t >= 2 && (t - 2) % GAP == 0 && (t - 2) / GAP < n) exp_ej = coin_mask(coins[(t - 2) / GAP]);
         check("ej", ej_now(), exp_ej);
         check("busy", busy, 1);
         check("done", done, t == done_t);
         if (t >= 2) begin
            r = ch;
            for (int j = 0; j < n && 2 + j * GAP < t; j++) r -= coins[j];
            check("remaining", remaining, r);
         end
      end
      @(posedge clk); @(negedge clk);
      vend_req = 1'b0;
      check("post_busy", busy, 0);
      check("post_done", done, 0);
      check("post_ej", ej_now(), 0);
      check("residue", remaining, rem);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ej", ej_now(), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_remaining", remaining, 0);
      rst_n = 1'b1;
      @(negedge clk);
      vend(300, 195, 0, -1, -1);
      vend(255, 240, 0, -1, -1);
      vend(0, 285, 1, -1, -1);
      vend(100, 120, 0, -1, -1);
      vend(500, 55, 0, 5, -1);
      vend(400, 100, 0, -1, 7);
      vend(300, 195, 0, -1, -1);
      vend(2047, 0, 0, -1, -1);
      vend(5, 0, 0, -1, -1);
      vend(4, 0, 0, -1, -1);
      vend(120, 120, 0, 1, -1);
      for (int k = 0; k < 120; k++) begin
         int p = $urandom_range(0, 1200);
         int pr = $urandom_range(0, 1200);
         int c = ($urandom_range(0, 7) == 0) ? 1 : 0;
         int xr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : -1;
         int ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 10)) : -1;
         vend(p, pr, c, xr, ab);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
